// File: rtl/rc_osc_mon_pkg.sv
// Shared types and defaults for the 16 MHz RC oscillator monitor.
package rc_osc_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    MEASURE = 3'd2,
    CHECK   = 3'd3,
    HOLD    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam int WIN_CYCLES_DEF     = 1000;
  localparam int CNT_W_DEF          = 16;
  localparam int TIMEOUT_CYCLES_DEF = 2048;

  // Inclusive range test; an inverted range (lo > hi) never matches.
  function automatic logic in_range(input logic [31:0] v,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    if ((v >= lo) && (v <= hi)) begin
      in_range = 1'b1;
    end else begin
      in_range = 1'b0;
    end
  endfunction

endpackage

// File: rtl/rc_osc_edge_sync.sv
// Brings the free-running oscillator output into the clk domain and
// flags its rising edges with a single-cycle pulse.
module rc_osc_edge_sync (
  input  logic clk,
  input  logic resetb,
  input  logic din,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic sync3_r;

  // Two-flop synchronizer followed by a delay flop for edge detection.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign rise = sync2_r & ~sync3_r;

endmodule

// File: rtl/rc_osc_16m_monitor.sv
// Enables the RC oscillator, times its startup and qualifies its edge count
// over fixed clk windows, reporting ready / sticky fault.
module rc_osc_16m_monitor
  import rc_osc_mon_pkg::*;
#(
  parameter int WIN_CYCLES     = WIN_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             en,
  input  logic             cont,
  input  logic [CNT_W-1:0] cnt_lo,
  input  logic [CNT_W-1:0] cnt_hi,
  input  logic             osc_dout,
  output logic             osc_ena,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] count,
  output logic             count_valid
);

  localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  state_t           state_s;
  logic             rise_s;
  logic             pass_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic [CNT_W-1:0] win_cnt_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic             osc_ena_r;
  logic             ready_r;
  logic             fault_r;
  logic             count_valid_r;
  logic [CNT_W-1:0] count_r;
  logic             osc_ena_s;
  logic             ready_s;
  logic             fault_s;
  logic             count_valid_s;
  logic [CNT_W-1:0] count_s;

  rc_osc_edge_sync u_edge_sync (
    .clk    (clk),
    .resetb (resetb),
    .din    (osc_dout),
    .rise   (rise_s)
  );

  assign pass_s = in_range(32'(edge_cnt_r), 32'(cnt_lo), 32'(cnt_hi));

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; dropping en wins over every other transition.
  always_comb begin
    state_s = state_r;
    if ((state_r != IDLE) && !en) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (en) state_s = START;
          else    state_s = IDLE;
        end
        START: begin
          if (rise_s)                    state_s = MEASURE;
          else if (to_cnt_r == TO_LAST)  state_s = FAULT;
          else                           state_s = START;
        end
        MEASURE: begin
          if (win_cnt_r == WIN_LAST) state_s = CHECK;
          else                       state_s = MEASURE;
        end
        CHECK: begin
          if (!pass_s)   state_s = FAULT;
          else if (cont) state_s = MEASURE;
          else           state_s = HOLD;
        end
        HOLD:    state_s = HOLD;
        FAULT:   state_s = FAULT;
        default: state_s = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state, with the CHECK verdict overriding ready.
  always_comb begin
    osc_ena_s     = 1'b0;
    ready_s       = 1'b0;
    fault_s       = 1'b0;
    count_valid_s = 1'b0;
    count_s       = count_r;
    case (state_s)
      START, MEASURE, CHECK: begin
        osc_ena_s = 1'b1;
        ready_s   = ready_r;
      end
      HOLD: begin
        osc_ena_s = 1'b1;
        ready_s   = 1'b1;
      end
      FAULT: begin
        fault_s = 1'b1;
      end
      default: begin
        osc_ena_s = 1'b0;
      end
    endcase
    if ((state_r == CHECK) && (state_s != IDLE)) begin
      count_valid_s = 1'b1;
      count_s       = edge_cnt_r;
      ready_s       = pass_s;
    end else begin
      count_valid_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      osc_ena_r     <= 1'b0;
      ready_r       <= 1'b0;
      fault_r       <= 1'b0;
      count_valid_r <= 1'b0;
      count_r       <= CNT_ZERO;
    end else begin
      osc_ena_r     <= osc_ena_s;
      ready_r       <= ready_s;
      fault_r       <= fault_s;
      count_valid_r <= count_valid_s;
      count_r       <= count_s;
    end
  end

  // Timeout, window and edge counters; the CHECK-cycle edge seeds the next window.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      to_cnt_r   <= TO_ZERO;
      win_cnt_r  <= CNT_ZERO;
      edge_cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        START: begin
          to_cnt_r   <= to_cnt_r + TO_ONE;
          win_cnt_r  <= CNT_ZERO;
          edge_cnt_r <= CNT_ZERO;
        end
        MEASURE: begin
          if (win_cnt_r == WIN_LAST) win_cnt_r <= CNT_ZERO;
          else                       win_cnt_r <= win_cnt_r + CNT_ONE;
          if (rise_s && (edge_cnt_r != CNT_MAX)) edge_cnt_r <= edge_cnt_r + CNT_ONE;
          else                                   edge_cnt_r <= edge_cnt_r;
        end
        CHECK: begin
          win_cnt_r <= CNT_ZERO;
          if (rise_s) edge_cnt_r <= CNT_ONE;
          else        edge_cnt_r <= CNT_ZERO;
        end
        HOLD, FAULT: begin
          to_cnt_r   <= to_cnt_r;
          win_cnt_r  <= win_cnt_r;
          edge_cnt_r <= edge_cnt_r;
        end
        default: begin
          to_cnt_r   <= TO_ZERO;
          win_cnt_r  <= CNT_ZERO;
          edge_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign osc_ena     = osc_ena_r;
  assign ready       = ready_r;
  assign fault       = fault_r;
  assign count       = count_r;
  assign count_valid = count_valid_r;

endmodule

// File: tb/tb_rc_osc_16m_monitor.sv
// Randomized bench for rc_osc_16m_monitor: a phase-accumulator oscillator
// model with per-cycle level history feeds an edge/window reference.
`timescale 1ns/1ps
module tb_rc_osc_16m_monitor;

  localparam int WIN   = 1000;
  localparam int TOUT  = 2048;
  localparam int LVL_N = 65536;

  logic        clk = 1'b0;
  logic        resetb;
  logic        en;
  logic        cont;
  logic [15:0] cnt_lo;
  logic [15:0] cnt_hi;
  logic        osc_dout = 1'b0;
  logic        osc_ena;
  logic        ready;
  logic        fault;
  logic [15:0] count;
  logic        count_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lo_i, hi_i;

  // Oscillator model controls (phase in 1/10000 of an oscillator period per clk).
  bit osc_run    = 1'b0;
  int osc_start  = 0;
  int phase      = 0;
  int phase_init = 0;
  int step_a     = 3200;
  int step_b     = 3200;
  int step_at    = 1 << 30;
  bit lvl [0:LVL_N-1];

  rc_osc_16m_monitor #(
    .WIN_CYCLES     (WIN),
    .CNT_W          (16),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .en          (en),
    .cont        (cont),
    .cnt_lo      (cnt_lo),
    .cnt_hi      (cnt_hi),
    .osc_dout    (osc_dout),
    .osc_ena     (osc_ena),
    .ready       (ready),
    .fault       (fault),
    .count       (count),
    .count_valid (count_valid)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator: level driven per clk cycle and recorded for the reference.
  always @(negedge clk) begin
    if (osc_run && (cyc >= osc_start)) begin
      if (cyc == osc_start) begin
        phase = phase_init;
      end else begin
        phase = phase + ((cyc >= step_at) ? step_b : step_a);
        if (phase >= 10000) phase = phase - 10000;
      end
      osc_dout = (phase < 5000);
    end else begin
      osc_dout = 1'b0;
    end
    if (cyc < LVL_N) lvl[cyc] = osc_dout;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A rise driven in cycle r reaches the counters as an edge in cycle r+2.
  function automatic bit edge_m(int c);
    if ((c < 3) || (c >= LVL_N)) return 1'b0;
    return lvl[c-2] && !lvl[c-3];
  endfunction

  function automatic int count_edges(int a, int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (edge_m(c)) n++;
    return n;
  endfunction

  function automatic int first_edge(int a, int b);
    for (int c = a; c <= b; c++) if (edge_m(c)) return c;
    return -1;
  endfunction

  task automatic set_thr(input int lo, input int hi);
    lo_i   = lo;
    hi_i   = hi;
    cnt_lo = 16'(lo);
    cnt_hi = 16'(hi);
  endtask

  task automatic wait_cv(input int budget, output bit seen, output int cv);
    seen = 1'b0;
    cv   = 0;
    for (int i = 0; (i < budget) && !seen; i++) begin
      @(negedge clk);
      if (count_valid === 1'b1) begin
        seen = 1'b1;
        cv   = cyc;
      end
    end
  endtask

  task automatic start_run(input int step, input int ph, output int start_c);
    @(negedge clk);
    en         = 1'b1;
    start_c    = cyc + 1;
    osc_start  = cyc + 350 + int'($urandom_range(0, 30));
    phase_init = ph;
    step_a     = step;
    step_b     = step;
    step_at    = 1 << 30;
    osc_run    = 1'b1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    en      = 1'b0;
    osc_run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // First window: edges after the trigger edge for WIN cycles; later windows
  // span the CHECK cycle plus WIN measuring cycles.
  task automatic qualify(input int nwin, input int start_c, output int last_cnt);
    int cv, t0, a, b, k, expc;
    bit seen, pass;
    k = 0;
    last_cnt = 0;
    for (int w = 0; w < nwin; w++) begin
      wait_cv((w == 0) ? 4000 : WIN + 50, seen, cv);
      check("cv_seen", 32'(seen), 32'd1);
      if (!seen) return;
      if (w == 0) begin
        t0 = first_edge(start_c, cv);
        a  = t0 + 1;
        b  = t0 + WIN;
      end else begin
        a = k;
        b = k + WIN;
      end
      check("cv_cycle", cv, b + 2);
      expc = count_edges(a, b);
      pass = (expc >= lo_i) && (expc <= hi_i);
      check("count", 32'(count), expc);
      check("ready", 32'(ready), 32'(pass));
      check("fault", 32'(fault), 32'(!pass));
      check("osc_ena", 32'(osc_ena), 32'(pass));
      k = cv - 1;
      last_cnt = expc;
      if (!pass) break;
    end
  endtask

  initial begin
    int s, lc, pulses;
    resetb = 1'b0;
    en     = 1'b0;
    cont   = 1'b0;
    set_thr(300, 340);
    repeat (3) @(negedge clk);
    check("rst_osc_ena", 32'(osc_ena), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_cv", 32'(count_valid), 32'd0);
    resetb = 1'b1;
    repeat (3) @(negedge clk);

    // Single qualification at 16 MHz, then HOLD.
    cont = 1'b0;
    start_run(3200, int'($urandom_range(0, 9999)), s);
    @(negedge clk);
    check("ena_rise", 32'(osc_ena), 32'd1);
    qualify(1, s, lc);
    pulses = 0;
    repeat (2500) begin
      @(negedge clk);
      if (count_valid === 1'b1) pulses++;
    end
    check("hold_cv_pulses", pulses, 0);
    check("hold_ready", 32'(ready), 32'd1);
    check("hold_osc_ena", 32'(osc_ena), 32'd1);
    check("hold_count", 32'(count), lc);
    go_idle();

    // Startup timeout with the oscillator stuck low.
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("to_osc_ena", 32'(osc_ena), 32'd1);
    repeat (TOUT - 1) @(negedge clk);
    check("to_early", 32'(fault), 32'd0);
    @(negedge clk);
    check("to_fault", 32'(fault), 32'd1);
    check("to_osc_ena_off", 32'(osc_ena), 32'd0);
    check("to_ready", 32'(ready), 32'd0);
    go_idle();

    // 12 MHz in continuous mode faults; en drop clears, re-raise restarts.
    cont = 1'b1;
    start_run(2400, int'($urandom_range(0, 9999)), s);
    qualify(3, s, lc);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_ready", 32'(ready), 32'd0);
    check("clr_osc_ena", 32'(osc_ena), 32'd0);
    check("clr_count", 32'(count), lc);
    en = 1'b1;
    @(negedge clk);
    check("restart_osc_ena", 32'(osc_ena), 32'd1);
    check("restart_fault", 32'(fault), 32'd0);
    go_idle();

    // 16 MHz stepped to 20 MHz mid-run in continuous mode.
    cont = 1'b1;
    start_run(3200, int'($urandom_range(0, 9999)), s);
    step_b  = 4000;
    step_at = osc_start + 1300 + int'($urandom_range(0, 400));
    qualify(6, s, lc);
    check("step_fault", 32'(fault), 32'd1);
    go_idle();

    // Boundaries on an exact 320-edge window whose last cycle carries an edge.
    cont = 1'b0;
    set_thr(320, 320);
    start_run(3200, int'($urandom_range(0, 3199)), s);
    qualify(1, s, lc);
    go_idle();
    set_thr(321, 340);
    start_run(3200, int'($urandom_range(0, 3199)), s);
    qualify(1, s, lc);
    go_idle();
    set_thr(340, 300);
    start_run(3200, int'($urandom_range(0, 3199)), s);
    qualify(1, s, lc);
    go_idle();

    // Asynchronous reset mid-measurement, then requalify with en held high.
    set_thr(300, 340);
    cont = 1'b1;
    start_run(3200, int'($urandom_range(0, 3199)), s);
    qualify(1, s, lc);
    repeat (300) @(negedge clk);
    #3;
    resetb  = 1'b0;
    osc_run = 1'b0;
    #1;
    check("arst_osc_ena", 32'(osc_ena), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_cv", 32'(count_valid), 32'd0);
    repeat (4) @(negedge clk);
    cont       = 1'b0;
    resetb     = 1'b1;
    s          = cyc + 1;
    osc_start  = cyc + 350 + int'($urandom_range(0, 30));
    phase_init = int'($urandom_range(0, 9999));
    step_a     = 3200;
    step_b     = 3200;
    step_at    = 1 << 30;
    osc_run    = 1'b1;
    qualify(1, s, lc);
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
